// File: rtl/fifo_status.sv
// fifo_status: occupancy tracking and Pause/Continue flow-control flags for
// four independent FIFO channels.
// Optional feature macro: FIFO_STATUS_ERR_EN. When it is defined, err carries
// sticky per-channel overflow/underflow flags. When it is undefined, err is
// tied to zero and overflow/underflow are silently ignored.
//
// Handshake: push[i]/pop[i] are single-cycle strobes sampled on each rising
// CLK edge. There is no back-pressure. The producer and consumer are expected
// to honour full/empty and Pause/Continue. Strobes that would overflow or
// underflow the counter are absorbed without corrupting it.
//
// Each channel's flow FSM state is visible directly on Pause
// (Pause[i]=1 <=> PAUSED).
module fifo_status #(
   parameter int DEPTH  = 8,
   parameter int HI_DEF = 6,
   parameter int LO_DEF = 2
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic       set_init,
   input  logic [3:0] hi_in,
   input  logic [3:0] lo_in,
   input  logic [3:0] push,
   input  logic [3:0] pop,
   output logic [3:0] empty,
   output logic [3:0] full,
   output logic [3:0] Pause,
   output logic [3:0] Continue,
   output logic [3:0] err
);

   localparam int         NCH     = 4;
   localparam logic [3:0] DEPTH_C = 4'(DEPTH);
   localparam logic [3:0] HI_C    = 4'(HI_DEF);
   localparam logic [3:0] LO_C    = 4'(LO_DEF);

   typedef enum logic {FLOW = 1'b0, PAUSED = 1'b1} state_t;

   logic [3:0]     count_q [NCH];
   logic [3:0]     count_d [NCH];
   state_t         state_q [NCH];
   state_t         state_d [NCH];
   logic [3:0]     hi_q;
   logic [3:0]     lo_q;
   logic [NCH-1:0] ovf;
   logic [NCH-1:0] udf;
   logic [NCH-1:0] empty_d;
   logic [NCH-1:0] full_d;
   logic [NCH-1:0] cont_d;
   logic           load_ok;

   // Next occupancy per channel, plus overflow/underflow detection.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         count_d[i] = count_q[i];
         ovf[i]     = 1'b0;
         udf[i]     = 1'b0;
         case ({push[i], pop[i]})
            2'b10: begin
               if (count_q[i] < DEPTH_C) count_d[i] = count_q[i] + 4'd1;
               else                      ovf[i]     = 1'b1;
            end
            2'b01: begin
               if (count_q[i] != 4'd0) count_d[i] = count_q[i] - 4'd1;
               else                    udf[i]     = 1'b1;
            end
            2'b11: begin
               // Pop of an empty FIFO is suppressed; the push still lands.
               if (count_q[i] == 4'd0) begin
                  count_d[i] = 4'd1;
                  udf[i]     = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Flow FSM next state and status flags, all from the post-update count.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         state_d[i] = state_q[i];
         case (state_q[i])
            FLOW:    if (count_d[i] >= hi_q) state_d[i] = PAUSED;
            PAUSED:  if (count_d[i] <= lo_q) state_d[i] = FLOW;
            default: state_d[i] = FLOW;
         endcase
         empty_d[i] = (count_d[i] == 4'd0);
         full_d[i]  = (count_d[i] == DEPTH_C);
         cont_d[i]  = (state_q[i] == PAUSED) && (state_d[i] == FLOW);
      end
   end

   // A threshold pair is accepted only if it leaves a hysteresis band inside the FIFO.
   always_comb begin
      load_ok = (lo_in < hi_in) && (hi_in <= DEPTH_C);
   end

   // Counters, FSM states and registered status flags.
   always_ff @(posedge CLK) begin
      if (!reset) begin
         for (int i = 0; i < NCH; i++) begin
            count_q[i] <= 4'd0;
            state_q[i] <= FLOW;
         end
         empty    <= 4'hF;
         full     <= 4'h0;
         Continue <= 4'h0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            count_q[i] <= count_d[i];
            state_q[i] <= state_d[i];
         end
         empty    <= empty_d;
         full     <= full_d;
         Continue <= cont_d;
      end
   end

   // Threshold registers; a new pair takes effect on the edge after it is loaded.
   always_ff @(posedge CLK) begin
      if (!reset) begin
         hi_q <= HI_C;
         lo_q <= LO_C;
      end else if (set_init && load_ok) begin
         hi_q <= hi_in;
         lo_q <= lo_in;
      end
   end

   // Pause is the FSM state itself.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         Pause[i] = (state_q[i] == PAUSED);
      end
   end

`ifdef FIFO_STATUS_ERR_EN
   logic [NCH-1:0] err_q;

   // Sticky error flags, cleared only by reset.
   always_ff @(posedge CLK) begin
      if (!reset) err_q <= '0;
      else        err_q <= err_q | ovf | udf;
   end

   assign err = err_q;
`else
   logic unused_err;
   assign unused_err = ^{ovf, udf};
   assign err        = 4'h0;
`endif

endmodule

// File: tb/tb_fifo_status.sv
// tb_fifo_status: directed test of fifo_status with default parameters
// (DEPTH=8, HI_DEF=6, LO_DEF=2). Expected err values follow
// FIFO_STATUS_ERR_EN.
module tb_fifo_status;

   logic       CLK;
   logic       reset;
   logic       set_init;
   logic [3:0] hi_in;
   logic [3:0] lo_in;
   logic [3:0] push;
   logic [3:0] pop;
   logic [3:0] empty;
   logic [3:0] full;
   logic [3:0] Pause;
   logic [3:0] Continue;
   logic [3:0] err;

   int total;
   int bad;

`ifdef FIFO_STATUS_ERR_EN
   localparam bit ERR_ON = 1'b1;
`else
   localparam bit ERR_ON = 1'b0;
`endif

   fifo_status #(.DEPTH(8), .HI_DEF(6), .LO_DEF(2)) dut (
      .CLK      (CLK),
      .reset    (reset),
      .set_init (set_init),
      .hi_in    (hi_in),
      .lo_in    (lo_in),
      .push     (push),
      .pop      (pop),
      .empty    (empty),
      .full     (full),
      .Pause    (Pause),
      .Continue (Continue),
      .err      (err)
   );

   // clock / reset block
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   function automatic logic [3:0] exp_err(input logic [3:0] v);
      return ERR_ON ? v : 4'h0;
   endfunction

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // driver: apply strobes for one edge, then sample 1 time unit after it
   task automatic cyc(input logic [3:0] pu, input logic [3:0] po);
      push = pu;
      pop  = po;
      @(posedge CLK);
      #1;
      push = 4'h0;
      pop  = 4'h0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      cyc(4'h0, 4'h0);
      reset = 1'b1;
   endtask

   task automatic load_thr(input logic [3:0] hi, input logic [3:0] lo);
      set_init = 1'b1;
      hi_in    = hi;
      lo_in    = lo;
      cyc(4'h0, 4'h0);
      set_init = 1'b0;
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      reset    = 1'b0;
      set_init = 1'b0;
      hi_in    = 4'h0;
      lo_in    = 4'h0;
      push     = 4'h0;
      pop      = 4'h0;

      // reset held for two edges
      cyc(4'h0, 4'h0);
      cyc(4'h0, 4'h0);
      check("rst_empty", empty, 4'hF);
      check("rst_full", full, 4'h0);
      check("rst_pause", Pause, 4'h0);
      check("rst_cont", Continue, 4'h0);
      check("rst_err", err, 4'h0);
      reset = 1'b1;

      // fill channel 0
      for (int k = 0; k < 5; k++) cyc(4'h1, 4'h0);
      check("fill5_pause", Pause, 4'h0);
      cyc(4'h1, 4'h0);
      check("fill6_pause", Pause, 4'h1);
      check("fill6_empty", empty, 4'hE);
      cyc(4'h1, 4'h0);
      check("fill7_full", full, 4'h0);
      cyc(4'h1, 4'h0);
      check("fill8_full", full, 4'h1);
      check("fill8_pause", Pause, 4'h1);

      // overflow: count held at 8
      cyc(4'h1, 4'h0);
      check("ovf_full", full, 4'h1);
      check("ovf_err", err, exp_err(4'h1));

      // drain channel 0 through the hysteresis band
      for (int k = 0; k < 5; k++) cyc(4'h0, 4'h1);
      check("drain3_pause", Pause, 4'h1);
      check("drain3_cont", Continue, 4'h0);
      check("drain3_full", full, 4'h0);
      cyc(4'h0, 4'h1);
      check("drain2_pause", Pause, 4'h0);
      check("drain2_cont", Continue, 4'h1);
      cyc(4'h0, 4'h0);
      check("cont_pulse_end", Continue, 4'h0);
      cyc(4'h0, 4'h1);
      check("drain1_empty", empty, 4'hE);
      cyc(4'h0, 4'h1);
      check("drain0_empty", empty, 4'hF);

      // underflow: push+pop on empty ch1, pop-only on empty ch3
      cyc(4'h2, 4'h2);
      check("udf_pp_empty", empty, 4'hD);
      check("udf_pp_err", err, exp_err(4'h3));
      cyc(4'h0, 4'h8);
      check("udf_pop_empty", empty, 4'hD);
      check("udf_pop_err", err, exp_err(4'hB));
      cyc(4'h0, 4'h2);
      check("udf_cnt1_empty", empty, 4'hF);

      // threshold load hi=4 lo=1
      do_reset();
      check("rst2_err", err, 4'h0);
      load_thr(4'd4, 4'd1);
      for (int k = 0; k < 3; k++) cyc(4'h1, 4'h0);
      check("thr_c3_pause", Pause, 4'h0);
      cyc(4'h1, 4'h0);
      check("thr_c4_pause", Pause, 4'h1);
      cyc(4'h0, 4'h1);
      cyc(4'h0, 4'h1);
      check("thr_c2_pause", Pause, 4'h1);
      cyc(4'h0, 4'h1);
      check("thr_c1_pause", Pause, 4'h0);
      check("thr_c1_cont", Continue, 4'h1);

      // rejected loads: lo>hi, then hi>DEPTH; 4/1 must remain
      load_thr(4'd3, 4'd5);
      load_thr(4'd9, 4'd2);
      for (int k = 0; k < 3; k++) cyc(4'h2, 4'h0);
      check("bad_c3_pause", Pause, 4'h0);
      cyc(4'h2, 4'h0);
      check("bad_c4_pause", Pause, 4'h2);
      cyc(4'h0, 4'h2);
      cyc(4'h0, 4'h2);
      check("bad_c2_pause", Pause, 4'h2);
      cyc(4'h0, 4'h2);
      check("bad_c1_pause", Pause, 4'h0);
      check("bad_c1_cont", Continue, 4'h2);

      // simultaneous push+pop at count 5 on all channels
      do_reset();
      for (int k = 0; k < 5; k++) cyc(4'hF, 4'h0);
      check("all5_pause", Pause, 4'h0);
      check("all5_empty", empty, 4'h0);
      for (int k = 0; k < 3; k++) begin
         cyc(4'hF, 4'hF);
         check("pp_pause", Pause, 4'h0);
         check("pp_cont", Continue, 4'h0);
         check("pp_empty", empty, 4'h0);
         check("pp_full", full, 4'h0);
      end
      cyc(4'hF, 4'h0);
      check("all6_pause", Pause, 4'hF);

      // mid-operation reset with push on every channel
      reset = 1'b0;
      cyc(4'hF, 4'h0);
      reset = 1'b1;
      check("midrst_empty", empty, 4'hF);
      check("midrst_full", full, 4'h0);
      check("midrst_pause", Pause, 4'h0);
      check("midrst_cont", Continue, 4'h0);
      cyc(4'h0, 4'h0);
      check("after_rst_cont", Continue, 4'h0);
      check("after_rst_empty", empty, 4'hF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
